// File: rtl/matmul_result_drain_pkg.sv
// ---------------------------------------------------------------------------
// matmul_result_drain_pkg
// Shared definitions for the matmul result drain block: default element,
// address and row-width constants plus the drain FSM state encoding.
// ---------------------------------------------------------------------------
package matmul_result_drain_pkg;

    localparam int DEF_DWIDTH          = 16;
    localparam int DEF_BB_MAT_MUL_SIZE = 4;
    localparam int DEF_AWIDTH          = 7;

    // Drain FSM states. IDLE waits for a done_mat_mul rising edge, ISSUE
    // walks the read addresses, FLUSH waits for the last words to leave the
    // output stream, DONE pulses drain_done for one cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_t;

endpackage

// File: rtl/matmul_drain_fifo.sv
// ---------------------------------------------------------------------------
// matmul_drain_fifo
// Synchronous FIFO used as the output skid buffer of the result drain.
// Pointers wrap modulo DEPTH (DEPTH need not be a power of two).
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (clears pointers and count)
//   i_push   in   write i_data this cycle (ignored when full and not popping)
//   i_data   in   WIDTH-bit write data
//   i_pop    in   remove the head entry this cycle (ignored when empty)
//   o_data   out  head entry (undefined content when empty)
//   o_empty  out  no entries stored
//   o_count  out  number of entries stored, 0..DEPTH
// ---------------------------------------------------------------------------
module matmul_drain_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop  = i_pop && (r_count != '0);
    // A full FIFO can still accept a word in the same cycle its head leaves.
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/matmul_result_drain.sv
// ---------------------------------------------------------------------------
// matmul_result_drain
// After the compute array signals completion (rising edge of done_mat_mul),
// reads NUM_WORDS words from the C memories starting at BASE_ADDR and
// streams them out in address order over a valid/ready interface. Reads are
// only issued while the skid FIFO has room for every word still in flight,
// so a stalled consumer never causes a returned word to be lost.
//
// Handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both high; out_valid and out_data do not depend on
// out_ready, and out_data is held until the transfer happens.
//
// Ports
//   clk                      in   rising-edge clock
//   reset_n                  in   asynchronous active-low reset
//   done_mat_mul             in   completion level from the compute array
//   enable_reading_from_mem  out  addr_pi owns the C-memory address path
//   addr_pi                  out  C-memory read address
//   data_from_out_mat        in   ORed C-memory read data, READ_LATENCY late
//   out_data                 out  stream word (zero when out_valid is low)
//   out_valid / out_ready    out/in stream handshake
//   out_last                 out  marks word NUM_WORDS-1
//   busy                     out  drain in progress (trigger to drain_done)
//   drain_done               out  one-cycle pulse after the final transfer
//   dbg_state                out  current FSM state
//   dbg_fifo_count           out  skid FIFO occupancy
// ---------------------------------------------------------------------------
module matmul_result_drain
    import matmul_result_drain_pkg::*;
#(
    parameter  int DWIDTH          = DEF_DWIDTH,
    parameter  int BB_MAT_MUL_SIZE = DEF_BB_MAT_MUL_SIZE,
    parameter  int AWIDTH          = DEF_AWIDTH,
    parameter  int NUM_WORDS       = 8,
    parameter  int BASE_ADDR       = 0,
    parameter  int READ_LATENCY    = 3,
    parameter  int FIFO_DEPTH      = 4,
    localparam int WW              = BB_MAT_MUL_SIZE * DWIDTH,
    localparam int FCW             = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              done_mat_mul,
    output logic              enable_reading_from_mem,
    output logic [AWIDTH-1:0] addr_pi,
    input  logic [WW-1:0]     data_from_out_mat,
    output logic [WW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              drain_done,
    output drain_state_t      dbg_state,
    output logic [FCW-1:0]    dbg_fifo_count
);

    localparam int NCW = $clog2(NUM_WORDS + 1);
    localparam int ICW = $clog2(READ_LATENCY + 1);
    localparam int SCW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

    drain_state_t        r_state;
    drain_state_t        w_next_state;
    logic                r_done_prev;
    logic                r_armed;
    logic [AWIDTH-1:0]   r_next_addr;
    logic [AWIDTH-1:0]   r_last_addr;
    logic [NCW-1:0]      r_issue_cnt;
    logic [NCW-1:0]      r_out_cnt;
    logic [READ_LATENCY-1:0] r_tag;

    logic                w_trigger;
    logic                w_start;
    logic [ICW-1:0]      w_inflight;
    logic [SCW-1:0]      w_pending;
    logic                w_issue;
    logic                w_last_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_final_pop;
    logic                w_fifo_empty;
    logic [WW-1:0]       w_fifo_head;
    logic [FCW-1:0]      w_fifo_count;

    // r_armed stays low for the first cycle after reset so that a level
    // already high at release is absorbed into r_done_prev, not seen as an edge.
    assign w_trigger = r_armed && done_mat_mul && !r_done_prev;
    assign w_start   = (r_state == ST_IDLE) && w_trigger;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + ICW'(r_tag[i]);
        end
    end

    // Slots already promised: stored words plus reads still in the memory
    // pipe. A word leaving this cycle frees its slot, which keeps the stream
    // gap-free when the consumer is always ready.
    assign w_pending    = SCW'(w_fifo_count) + SCW'(w_inflight) - SCW'(w_pop);
    assign w_issue      = (r_state == ST_ISSUE) && (w_pending < SCW'(FIFO_DEPTH));
    assign w_last_issue = w_issue && (r_issue_cnt == NCW'(NUM_WORDS - 1));

    assign w_push      = r_tag[READ_LATENCY-1];
    assign out_valid   = !w_fifo_empty;
    assign w_pop       = out_valid && out_ready;
    assign w_final_pop = w_pop && (r_out_cnt == NCW'(NUM_WORDS - 1));

    // The address of the read being issued; otherwise the last issued one.
    assign addr_pi = w_issue ? r_next_addr : r_last_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state            = r_state;
        enable_reading_from_mem = 1'b0;
        busy                    = 1'b0;
        drain_done              = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) w_next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                enable_reading_from_mem = 1'b1;
                busy                    = 1'b1;
                if (w_last_issue) w_next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                enable_reading_from_mem = 1'b1;
                busy                    = 1'b1;
                if (w_final_pop) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                busy         = 1'b1;
                drain_done   = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done_prev <= 1'b0;
            r_armed     <= 1'b0;
            r_next_addr <= AWIDTH'(BASE_ADDR);
            r_last_addr <= AWIDTH'(BASE_ADDR);
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
            r_tag       <= '0;
        end else begin
            r_done_prev <= done_mat_mul;
            r_armed     <= 1'b1;
            r_tag[0]    <= w_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (w_start) begin
                r_next_addr <= AWIDTH'(BASE_ADDR);
                r_issue_cnt <= '0;
                r_out_cnt   <= '0;
            end else begin
                if (w_issue) begin
                    // Natural AWIDTH overflow gives the modulo-2**AWIDTH wrap.
                    r_next_addr <= r_next_addr + 1'b1;
                    r_last_addr <= r_next_addr;
                    r_issue_cnt <= r_issue_cnt + 1'b1;
                end
                if (w_pop) r_out_cnt <= r_out_cnt + 1'b1;
            end
        end
    end

    matmul_drain_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (data_from_out_mat),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign out_data       = out_valid ? w_fifo_head : '0;
    assign out_last       = out_valid && (r_out_cnt == NCW'(NUM_WORDS - 1));
    assign dbg_state      = r_state;
    assign dbg_fifo_count = w_fifo_count;

endmodule
